// File: rtl/mic_pdm_decoder.sv
// PDM microphone receiver: generates micClk, synchronises micData and decimates by ones-count.
// Optional loudness flag is compiled in with `define MIC_LEVEL_DETECT_EN.
module mic_pdm_decoder #(
    parameter int CLK_DIV = 20,
    parameter int DECIM   = 64,
    parameter int THRESH  = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic                         micData,
    output logic                         micClk,
    output logic                         chSel,
    output logic [$clog2(DECIM+1)-1:0]   sampleOut,
    output logic                         sampleValid,
    output logic                         loud
);

    localparam int AW = $clog2(DECIM + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (DECIM < 2) begin : g_bad_decim
        $error("mic_pdm_decoder: DECIM must be at least 2");
    end
    if ((CLK_DIV < 1) || (THRESH < 0)) begin : g_bad_cfg
        $error("mic_pdm_decoder: CLK_DIV must be >= 1 and THRESH >= 0");
    end

    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_divCnt;
    logic          r_micClk;
    logic [AW-1:0] r_bitCnt;
    logic [AW-1:0] r_acc;
    logic [AW-1:0] r_sampleOut;
    logic          r_sampleValid;

    logic          w_divWrap;
    logic          w_capture;
    logic          w_lastBit;
    logic [AW-1:0] w_sum;

    assign w_divWrap = (r_divCnt == DW'(CLK_DIV - 1));
    // Capture on the high-to-low toggle, i.e. at the end of the micClk high phase.
    assign w_capture = w_divWrap & r_micClk;
    assign w_lastBit = (r_bitCnt == AW'(DECIM - 1));
    assign w_sum     = r_acc + AW'(r_sync2);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= micData;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_divCnt      <= '0;
            r_micClk      <= 1'b0;
            r_bitCnt      <= '0;
            r_acc         <= '0;
            r_sampleOut   <= '0;
            r_sampleValid <= 1'b0;
        end else if (!enable) begin
            // Partial window is dropped; sampleOut keeps the last completed value.
            r_divCnt      <= '0;
            r_micClk      <= 1'b0;
            r_bitCnt      <= '0;
            r_acc         <= '0;
            r_sampleValid <= 1'b0;
        end else begin
            r_sampleValid <= 1'b0;
            if (w_divWrap) begin
                r_divCnt <= '0;
                r_micClk <= ~r_micClk;
            end else begin
                r_divCnt <= r_divCnt + 1'b1;
            end
            if (w_capture) begin
                if (w_lastBit) begin
                    r_sampleOut   <= w_sum;
                    r_sampleValid <= 1'b1;
                    r_acc         <= '0;
                    r_bitCnt      <= '0;
                end else begin
                    r_acc    <= w_sum;
                    r_bitCnt <= r_bitCnt + 1'b1;
                end
            end
        end
    end

`ifdef MIC_LEVEL_DETECT_EN
    logic signed [AW:0] w_dev;
    logic        [AW:0] w_absDev;
    logic               r_loud;

    // One extra bit keeps the signed deviation from the mid-scale exact.
    assign w_dev    = $signed({1'b0, w_sum}) - $signed((AW + 1)'(DECIM / 2));
    assign w_absDev = w_dev[AW] ? -w_dev : w_dev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_loud <= 1'b0;
        end else if (enable && w_capture && w_lastBit) begin
            r_loud <= (int'({1'b0, w_absDev}) >= THRESH);
        end
    end

    assign loud = r_loud;
`else
    assign loud = 1'b0;
`endif

    assign micClk      = r_micClk;
    assign chSel       = 1'b0;
    assign sampleOut   = r_sampleOut;
    assign sampleValid = r_sampleValid;

endmodule
